// File: rtl/operator_pkg.sv
// operator_pkg
//   Shared types and constants for the multi-channel operator pipeline.
//   - op_e        : 3-bit per-channel operation code
//   - DEF_*       : default register map addresses
//   - sat_max/min : signed saturation limits for a given width (up to LIM_W bits)
//   - is_valid_op : true for codes that may be written into an op register
package operator_pkg;

   typedef enum logic [2:0] {
      OP_PASS    = 3'd0,   // z = a
      OP_ADD_SUB = 3'd1,   // z = a + b - c
      OP_SUB_SUB = 3'd2,   // z = a - b - c
      OP_MAC     = 3'd3,   // z = a * b + c
      OP_ACC     = 3'd4    // acc[ch] += a * b, z = new acc
   } op_e;

   localparam int DEF_OP_BASE  = 10;
   localparam int DEF_CNT_ADDR = 8;

   // Widest result the limit helpers can describe.
   localparam int LIM_W = 128;

   // Largest positive value of a w-bit signed number: 2^(w-1) - 1.
   function automatic logic signed [LIM_W-1:0] sat_max(input int w);
      logic [LIM_W-1:0] one;
      one = LIM_W'(1);
      return $signed((one << (w - 1)) - one);
   endfunction

   // Most negative value of a w-bit signed number: -(2^(w-1)).
   // Bitwise inversion of the positive limit gives exactly that in two's complement.
   function automatic logic signed [LIM_W-1:0] sat_min(input int w);
      return ~sat_max(w);
   endfunction

   function automatic logic is_valid_op(input logic [2:0] code);
      return code <= 3'd4;
   endfunction

endpackage

// File: rtl/operator_regs.sv
// operator_regs
//   Register block for operator_pipe: address decode, per-channel op-type
//   registers, accumulator clear strobes, transaction counter and readback.
//   Ports:
//     clk, rst_n              clock, asynchronous active-low reset
//     reg_wr, reg_rd          single-cycle write / read strobes
//     reg_addr, reg_wr_data   32-bit address and write data
//     reg_rd_data             read data, registered (valid 1 cycle after reg_rd)
//     xfer                    a result left the pipeline this cycle
//     op_type[NUM_CH]         current op code per channel
//     acc_clr[NUM_CH]         combinational strobe: clear that channel's accumulator
module operator_regs
   import operator_pkg::*;
#(
   parameter int NUM_CH   = 4,
   parameter int OP_BASE  = DEF_OP_BASE,
   parameter int CNT_ADDR = DEF_CNT_ADDR
)(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              reg_wr,
   input  logic              reg_rd,
   input  logic [31:0]       reg_addr,
   input  logic [31:0]       reg_wr_data,
   output logic [31:0]       reg_rd_data,
   input  logic              xfer,
   output op_e               op_type [NUM_CH],
   output logic [NUM_CH-1:0] acc_clr
);

   logic [NUM_CH-1:0] op_hit;
   logic              cnt_hit;
   logic [31:0]       cnt;
   logic [31:0]       rd_next;
   logic              unused_wr_bits;

   assign unused_wr_bits = ^reg_wr_data[31:3];

   always_comb begin
      op_hit = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         op_hit[i] = reg_wr && (reg_addr == 32'(OP_BASE + i));
      end
   end

   // An ignored (5..7) write leaves the op untouched and does not clear the accumulator.
   assign acc_clr = op_hit & {NUM_CH{is_valid_op(reg_wr_data[2:0])}};
   assign cnt_hit = reg_wr && (reg_addr == 32'(CNT_ADDR));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_CH; i++) begin
            op_type[i] <= OP_PASS;
         end
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            if (acc_clr[i]) begin
               op_type[i] <= op_e'(reg_wr_data[2:0]);
            end
         end
      end
   end

   // Clear takes priority over a same-cycle increment.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (cnt_hit) begin
         cnt <= '0;
      end else if (xfer) begin
         cnt <= cnt + 32'd1;
      end
   end

   // Readback samples pre-edge state, so a same-cycle write to the read address returns the old value.
   always_comb begin
      rd_next = '0;
      if (reg_addr == 32'(CNT_ADDR)) begin
         rd_next = cnt;
      end
      for (int i = 0; i < NUM_CH; i++) begin
         if (reg_addr == 32'(OP_BASE + i)) begin
            rd_next = {29'd0, op_type[i]};
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         reg_rd_data <= '0;
      end else if (reg_rd) begin
         reg_rd_data <= rd_next;
      end
   end

endmodule

// File: rtl/operator_pipe.sv
// operator_pipe
//   Two-stage valid/ready multi-channel operator. Each transaction carries a
//   channel and signed operands a, b, c; the channel's op code (programmed over
//   the register bus) selects pass, add/sub, sub/sub, multiply-add or a
//   saturating per-channel multiply-accumulate. Result is 2*DATA_W signed.
//   Ports:
//     clk, rst_n                        clock, asynchronous active-low reset
//     reg_wr, reg_rd, reg_addr,
//     reg_wr_data, reg_rd_data          register bus (see operator_regs)
//     in_valid, in_ready, in_ch, a, b, c  operand handshake
//     out_valid, out_ready, out_ch, z,
//     out_ovf, out_err                  result handshake; out_ovf marks a saturated
//                                       accumulate, out_err an out-of-range channel
module operator_pipe
   import operator_pkg::*;
#(
   parameter int DATA_W   = 32,
   parameter int NUM_CH   = 4,
   parameter int OP_BASE  = DEF_OP_BASE,
   parameter int CNT_ADDR = DEF_CNT_ADDR
)(
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       reg_wr,
   input  logic                       reg_rd,
   input  logic [31:0]                reg_addr,
   input  logic [31:0]                reg_wr_data,
   output logic [31:0]                reg_rd_data,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [3:0]                 in_ch,
   input  logic signed [DATA_W-1:0]   a,
   input  logic signed [DATA_W-1:0]   b,
   input  logic signed [DATA_W-1:0]   c,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [3:0]                 out_ch,
   output logic signed [2*DATA_W-1:0] z,
   output logic                       out_ovf,
   output logic                       out_err
);

   localparam int ACC_W = 2 * DATA_W;
   localparam logic signed [ACC_W-1:0] ACC_MAX = ACC_W'(sat_max(ACC_W));
   localparam logic signed [ACC_W-1:0] ACC_MIN = ACC_W'(sat_min(ACC_W));

   function automatic logic signed [ACC_W-1:0] sext(input logic signed [DATA_W-1:0] v);
      return ACC_W'(v);
   endfunction

   // Returns {ovf, value}. The sum is one bit wider than the accumulator;
   // differing top bits mean it left the representable range.
   function automatic logic [ACC_W:0] sat_acc(input logic signed [ACC_W:0] sum);
      if (sum[ACC_W] != sum[ACC_W-1]) begin
         return {1'b1, (sum[ACC_W] ? ACC_MIN : ACC_MAX)};
      end
      return {1'b0, sum[ACC_W-1:0]};
   endfunction

   op_e                     op_type [NUM_CH];
   logic [NUM_CH-1:0]       acc_clr;
   logic signed [ACC_W-1:0] acc [NUM_CH];

   logic                    adv_p1, accept, xfer, acc_we;
   logic                    in_err;
   op_e                     in_op;

   logic                    vld_p1, err_p1;
   logic [3:0]              ch_p1;
   op_e                     op_p1;
   logic signed [DATA_W-1:0] a_p1, b_p1, c_p1;
   logic signed [ACC_W-1:0] prod_p1;

   logic signed [ACC_W-1:0] sa_p1, sb_p1, sc_p1, acc_cur_p1, acc_sat_p1, res_p1;
   logic signed [ACC_W:0]   acc_sum_p1;
   logic                    acc_ovf_p1, ovf_p1;

   operator_regs #(
      .NUM_CH   (NUM_CH),
      .OP_BASE  (OP_BASE),
      .CNT_ADDR (CNT_ADDR)
   ) u_regs (
      .clk         (clk),
      .rst_n       (rst_n),
      .reg_wr      (reg_wr),
      .reg_rd      (reg_rd),
      .reg_addr    (reg_addr),
      .reg_wr_data (reg_wr_data),
      .reg_rd_data (reg_rd_data),
      .xfer        (xfer),
      .op_type     (op_type),
      .acc_clr     (acc_clr)
   );

   assign adv_p1   = !out_valid || out_ready;
   assign in_ready = !vld_p1 || adv_p1;
   assign accept   = in_valid && in_ready;
   assign xfer     = out_valid && out_ready;
   assign in_err   = {28'd0, in_ch} >= 32'(NUM_CH);

   // Op is snapshotted at accept; later register writes do not affect this transaction.
   always_comb begin
      in_op = OP_PASS;
      for (int i = 0; i < NUM_CH; i++) begin
         if (in_ch == 4'(i)) begin
            in_op = op_type[i];
         end
      end
   end

   // ---- Stage 1: register operands, channel, op and signed product ----
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_p1 <= 1'b0;
         ch_p1  <= '0;
         op_p1  <= OP_PASS;
         err_p1 <= 1'b0;
      end else if (in_ready) begin
         vld_p1 <= in_valid;
         if (in_valid) begin
            ch_p1  <= in_ch;
            op_p1  <= in_op;
            err_p1 <= in_err;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         a_p1    <= a;
         b_p1    <= b;
         c_p1    <= c;
         prod_p1 <= sext(a) * sext(b);
      end
   end

   // ---- Stage 1 -> 2: combine values, accumulate with saturation ----
   assign sa_p1 = sext(a_p1);
   assign sb_p1 = sext(b_p1);
   assign sc_p1 = sext(c_p1);

   always_comb begin
      acc_cur_p1 = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (ch_p1 == 4'(i)) begin
            acc_cur_p1 = acc[i];
         end
      end
   end

   assign acc_sum_p1 = {acc_cur_p1[ACC_W-1], acc_cur_p1} + {prod_p1[ACC_W-1], prod_p1};
   assign {acc_ovf_p1, acc_sat_p1} = sat_acc(acc_sum_p1);

   always_comb begin
      res_p1 = '0;
      ovf_p1 = 1'b0;
      if (!err_p1) begin
         case (op_p1)
            OP_PASS:    res_p1 = sa_p1;
            OP_ADD_SUB: res_p1 = sa_p1 + sb_p1 - sc_p1;
            OP_SUB_SUB: res_p1 = sa_p1 - sb_p1 - sc_p1;
            OP_MAC:     res_p1 = prod_p1 + sc_p1;
            OP_ACC: begin
               res_p1 = acc_sat_p1;
               ovf_p1 = acc_ovf_p1;
            end
            default:    res_p1 = '0;
         endcase
      end
   end

   assign acc_we = vld_p1 && adv_p1 && !err_p1 && (op_p1 == OP_ACC);

   // A register write clears the accumulator even if an accumulate lands the same cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_CH; i++) begin
            acc[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            if (acc_clr[i]) begin
               acc[i] <= '0;
            end else if (acc_we && (ch_p1 == 4'(i))) begin
               acc[i] <= acc_sat_p1;
            end
         end
      end
   end

   // ---- Stage 2: output register ----
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         z         <= '0;
         out_ch    <= '0;
         out_ovf   <= 1'b0;
         out_err   <= 1'b0;
      end else if (adv_p1) begin
         out_valid <= vld_p1;
         if (vld_p1) begin
            z       <= res_p1;
            out_ch  <= ch_p1;
            out_ovf <= ovf_p1;
            out_err <= err_p1;
         end
      end
   end

endmodule

// File: tb/tb_operator_pipe.sv
// tb_operator_pipe
//   Self-checking bench for operator_pipe (DATA_W=32, NUM_CH=4). A behavioural
//   model computes each expected result at accept time from the channel's op
//   code and a plain-arithmetic accumulator with range clamping; a scoreboard
//   process compares every output handshake and checks output stability while
//   stalled. Scenario tasks add their own directed comparisons.
module tb_operator_pipe;

   localparam int DATA_W   = 32;
   localparam int NUM_CH   = 4;
   localparam int OP_BASE  = 10;
   localparam int CNT_ADDR = 8;
   localparam logic signed [127:0] LIM_HI = 128'sh7FFF_FFFF_FFFF_FFFF;
   localparam logic signed [127:0] LIM_LO = -LIM_HI - 128'sd1;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              rst_n;
   logic              reg_wr, reg_rd;
   logic [31:0]       reg_addr, reg_wr_data, reg_rd_data;
   logic              in_valid, in_ready;
   logic [3:0]        in_ch;
   logic signed [31:0] a, b, c;
   logic              out_valid, out_ready;
   logic [3:0]        out_ch;
   logic signed [63:0] z;
   logic              out_ovf, out_err;

   typedef struct packed {
      logic signed [63:0] z;
      logic [3:0]         ch;
      logic               ovf;
      logic               err;
   } exp_t;

   exp_t              exp_q[$];
   int                checks = 0;
   int                errors = 0;
   int                out_count = 0;
   logic signed [63:0] last_z;
   logic              last_ovf, last_err;
   int                op_m [NUM_CH];
   longint            acc_m [NUM_CH];
   logic              stim_done;

   operator_pipe #(
      .DATA_W   (DATA_W),
      .NUM_CH   (NUM_CH),
      .OP_BASE  (OP_BASE),
      .CNT_ADDR (CNT_ADDR)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .reg_wr      (reg_wr),
      .reg_rd      (reg_rd),
      .reg_addr    (reg_addr),
      .reg_wr_data (reg_wr_data),
      .reg_rd_data (reg_rd_data),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_ch       (in_ch),
      .a           (a),
      .b           (b),
      .c           (c),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_ch      (out_ch),
      .z           (z),
      .out_ovf     (out_ovf),
      .out_err     (out_err)
   );

   // ---------------- reference model ----------------
   task automatic model_reset();
      for (int i = 0; i < NUM_CH; i++) begin
         op_m[i]  = 0;
         acc_m[i] = 0;
      end
      exp_q.delete();
   endtask

   task automatic model_accept(input logic [3:0] ch, input logic signed [31:0] av,
                               input logic signed [31:0] bv, input logic signed [31:0] cv);
      exp_t e;
      longint sa, sb, sc;
      logic signed [127:0] s;
      sa = longint'(av);
      sb = longint'(bv);
      sc = longint'(cv);
      e.ch = ch; e.ovf = 1'b0; e.err = 1'b0; e.z = '0;
      if (int'(ch) >= NUM_CH) begin
         e.err = 1'b1;
      end else begin
         case (op_m[ch])
            0: e.z = sa;
            1: e.z = sa + sb - sc;
            2: e.z = sa - sb - sc;
            3: e.z = sa * sb + sc;
            default: begin
               s = 128'(acc_m[ch]) + 128'(sa) * 128'(sb);
               if (s > LIM_HI) begin
                  s = LIM_HI; e.ovf = 1'b1;
               end else if (s < LIM_LO) begin
                  s = LIM_LO; e.ovf = 1'b1;
               end
               e.z = s[63:0];
               acc_m[ch] = longint'(e.z);
            end
         endcase
      end
      exp_q.push_back(e);
   endtask

   // ---------------- scoreboard ----------------
   task automatic monitor_loop();
      exp_t e;
      logic hold;
      logic signed [63:0] hz;
      logic [3:0] hch;
      logic hovf, herr;
      hold = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            hold = 1'b0;
            continue;
         end
         if (hold) begin
            checks++;
            if (!out_valid || z !== hz || out_ch !== hch || out_ovf !== hovf || out_err !== herr) begin
               errors++;
               $display("FAIL stall_hold: got valid=%0b z=%0d ch=%0d, required valid=1 z=%0d ch=%0d",
                        out_valid, z, out_ch, hz, hch);
            end
         end
         hold = out_valid && !out_ready;
         hz = z; hch = out_ch; hovf = out_ovf; herr = out_err;
         if (out_valid && out_ready) begin
            checks++;
            out_count++;
            last_z = z; last_ovf = out_ovf; last_err = out_err;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_output: got z=%0d ch=%0d, required no output", z, out_ch);
            end else begin
               e = exp_q.pop_front();
               if (z !== e.z || out_ch !== e.ch || out_ovf !== e.ovf || out_err !== e.err) begin
                  errors++;
                  $display("FAIL result: got z=%0d ch=%0d ovf=%0b err=%0b, required z=%0d ch=%0d ovf=%0b err=%0b",
                           z, out_ch, out_ovf, out_err, e.z, e.ch, e.ovf, e.err);
               end
            end
         end
      end
   endtask

   // ---------------- drivers ----------------
   task automatic reg_write(input logic [31:0] addr, input logic [31:0] data);
      reg_addr = addr; reg_wr_data = data; reg_wr = 1'b1;
      if (int'(addr) >= OP_BASE && int'(addr) < OP_BASE + NUM_CH && data[2:0] <= 3'd4) begin
         op_m[int'(addr) - OP_BASE]  = int'(data[2:0]);
         acc_m[int'(addr) - OP_BASE] = 0;
      end
      @(posedge clk); #1;
      reg_wr = 1'b0;
   endtask

   task automatic reg_read(input logic [31:0] addr, output logic [31:0] data);
      reg_addr = addr; reg_rd = 1'b1;
      @(posedge clk); #1;
      reg_rd = 1'b0;
      data = reg_rd_data;
   endtask

   task automatic send(input logic [3:0] ch, input logic signed [31:0] av,
                       input logic signed [31:0] bv, input logic signed [31:0] cv);
      in_ch = ch; a = av; b = bv; c = cv; in_valid = 1'b1;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (in_ready) begin
            model_accept(ch, av, bv, cv);
            @(posedge clk); #1;
            in_valid = 1'b0;
            return;
         end
      end
      checks++; errors++;
      $display("FAIL send_timeout: got in_ready=0 for 200 cycles, required 1");
      in_valid = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < 300; i++) begin
         @(posedge clk); #1;
         if (exp_q.size() == 0) return;
      end
      checks++; errors++;
      $display("FAIL drain_timeout: got pending=%0d, required 0", exp_q.size());
   endtask

   function automatic logic signed [31:0] pick();
      case ($urandom_range(0, 3))
         0: return 32'sh8000_0000;
         1: return 32'sh7FFF_FFFF;
         default: return $signed($urandom());
      endcase
   endfunction

   // ---------------- scenarios ----------------
   task automatic test_reset();
      logic [31:0] d;
      rst_n = 1'b1;
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || z !== 64'sd0 || out_ch !== 4'd0 ||
          out_ovf !== 1'b0 || out_err !== 1'b0 || reg_rd_data !== 32'd0) begin
         errors++;
         $display("FAIL reset_outputs: got rdy=%0b vld=%0b z=%0d ch=%0d ovf=%0b err=%0b rd=%0d, required 1 0 0 0 0 0 0",
                  in_ready, out_valid, z, out_ch, out_ovf, out_err, reg_rd_data);
      end
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      for (int i = 0; i < NUM_CH; i++) begin
         reg_read(32'(OP_BASE + i), d);
         checks++;
         if (d !== 32'd0) begin
            errors++;
            $display("FAIL reset_op%0d: got %0d, required 0", i, d);
         end
      end
      reg_read(CNT_ADDR, d);
      checks++;
      if (d !== 32'd0) begin
         errors++;
         $display("FAIL reset_cnt: got %0d, required 0", d);
      end
   endtask

   task automatic test_add_sub();
      reg_write(OP_BASE, 32'd1);
      send(4'd0, 100, 50, 10);
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL latency_early: got out_valid=%0b one cycle after accept, required 0", out_valid);
      end
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || z !== 64'sd140 || out_err !== 1'b0) begin
         errors++;
         $display("FAIL add_sub: got vld=%0b z=%0d err=%0b, required 1 140 0", out_valid, z, out_err);
      end
      drain();
   endtask

   task automatic test_back_to_back();
      logic [31:0] d;
      reg_write(CNT_ADDR, 32'd0);
      reg_write(OP_BASE + 1, 32'd2);
      reg_write(OP_BASE + 2, 32'd3);
      send(4'd1, 100, 50, 10);
      send(4'd2, -3, 7, 5);
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || z !== 64'sd40) begin
         errors++;
         $display("FAIL b2b_first: got vld=%0b z=%0d, required 1 40", out_valid, z);
      end
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || z !== -64'sd16) begin
         errors++;
         $display("FAIL b2b_second: got vld=%0b z=%0d, required 1 -16", out_valid, z);
      end
      drain();
      reg_read(CNT_ADDR, d);
      checks++;
      if (d !== 32'd2) begin
         errors++;
         $display("FAIL b2b_counter: got %0d, required 2", d);
      end
   endtask

   task automatic test_acc_stall();
      int base;
      reg_write(OP_BASE + 3, 32'd4);
      base = out_count;
      fork
         begin
            for (int i = 0; i < 4; i++) send(4'd3, 3, 4, 0);
         end
         begin
            repeat (2) @(posedge clk);
            #1 out_ready = 1'b0;
            repeat (3) @(posedge clk);
            #1 out_ready = 1'b1;
         end
      join
      drain();
      checks++;
      if (out_count - base !== 4 || last_z !== 64'sd48) begin
         errors++;
         $display("FAIL acc_stall: got outputs=%0d last_z=%0d, required 4 48", out_count - base, last_z);
      end
      reg_write(OP_BASE + 3, 32'd4);
      send(4'd3, 3, 4, 0);
      drain();
      checks++;
      if (last_z !== 64'sd12) begin
         errors++;
         $display("FAIL acc_rewrite_clear: got %0d, required 12", last_z);
      end
   endtask

   task automatic test_saturation();
      reg_write(OP_BASE + 3, 32'd4);
      for (int i = 0; i < 3; i++) send(4'd3, 32'sh8000_0000, 32'sh8000_0000, 0);
      drain();
      checks++;
      if (last_z !== 64'sh7FFF_FFFF_FFFF_FFFF || last_ovf !== 1'b1) begin
         errors++;
         $display("FAIL sat_pos: got z=%0d ovf=%0b, required z=%0d ovf=1", last_z, last_ovf, 64'sh7FFF_FFFF_FFFF_FFFF);
      end
      reg_write(OP_BASE + 3, 32'd4);
      for (int i = 0; i < 3; i++) send(4'd3, 32'sh8000_0000, 32'sh7FFF_FFFF, 0);
      drain();
      checks++;
      if (last_z !== 64'sh8000_0000_0000_0000 || last_ovf !== 1'b1) begin
         errors++;
         $display("FAIL sat_neg: got z=%0d ovf=%0b, required z=%0d ovf=1", last_z, last_ovf, 64'sh8000_0000_0000_0000);
      end
   endtask

   task automatic test_bad_inputs();
      logic [31:0] d;
      reg_write(OP_BASE, 32'd7);
      reg_read(OP_BASE, d);
      checks++;
      if (d !== 32'd1) begin
         errors++;
         $display("FAIL ignored_op_write: got %0d, required 1", d);
      end
      send(4'd5, 9, 9, 9);
      drain();
      checks++;
      if (last_err !== 1'b1 || last_z !== 64'sd0) begin
         errors++;
         $display("FAIL bad_channel: got err=%0b z=%0d, required err=1 z=0", last_err, last_z);
      end
      reg_read(32'd20, d);
      checks++;
      if (d !== 32'd0) begin
         errors++;
         $display("FAIL unmapped_read: got %0d, required 0", d);
      end
      // same-cycle write and read of one address returns the old value
      reg_addr = OP_BASE + 1; reg_wr_data = 32'd3; reg_wr = 1'b1; reg_rd = 1'b1;
      op_m[1] = 3; acc_m[1] = 0;
      @(posedge clk); #1;
      reg_wr = 1'b0; reg_rd = 1'b0;
      checks++;
      if (reg_rd_data !== 32'd2) begin
         errors++;
         $display("FAIL rd_wr_same_cycle: got %0d, required 2", reg_rd_data);
      end
      // counter clear on the same cycle as an output transfer
      reg_write(CNT_ADDR, 32'd0);
      out_ready = 1'b0;
      send(4'd0, 1, 2, 3);
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         if (out_valid) break;
      end
      out_ready = 1'b1;
      reg_write(CNT_ADDR, 32'd0);
      drain();
      reg_read(CNT_ADDR, d);
      checks++;
      if (d !== 32'd0) begin
         errors++;
         $display("FAIL cnt_clear_wins: got %0d, required 0", d);
      end
   endtask

   task automatic test_random();
      int base;
      for (int ch = 0; ch < NUM_CH; ch++) reg_write(32'(OP_BASE + ch), 32'($urandom_range(0, 4)));
      base = out_count;
      stim_done = 1'b0;
      fork
         begin
            for (int i = 0; i < 200; i++) begin
               send(4'($urandom_range(0, NUM_CH)), pick(), pick(), pick());
            end
            stim_done = 1'b1;
         end
         begin
            while (!stim_done) begin
               @(posedge clk); #1;
               out_ready = ($urandom_range(0, 3) != 0);
            end
            out_ready = 1'b1;
         end
      join
      drain();
      checks++;
      if (out_count - base !== 200) begin
         errors++;
         $display("FAIL random_count: got %0d outputs, required 200", out_count - base);
      end
   endtask

   task automatic test_reset_inflight();
      logic [31:0] d;
      out_ready = 1'b0;
      send(4'd0, 1, 1, 1);
      send(4'd1, 2, 2, 2);
      checks++;
      if (out_valid !== 1'b1) begin
         errors++;
         $display("FAIL inflight_setup: got out_valid=%0b, required 1", out_valid);
      end
      rst_n = 1'b0;
      #1;
      model_reset();
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || z !== 64'sd0) begin
         errors++;
         $display("FAIL inflight_reset: got vld=%0b rdy=%0b z=%0d, required 0 1 0", out_valid, in_ready, z);
      end
      out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      for (int i = 0; i < NUM_CH; i++) begin
         reg_read(32'(OP_BASE + i), d);
         checks++;
         if (d !== 32'd0) begin
            errors++;
            $display("FAIL post_reset_op%0d: got %0d, required 0", i, d);
         end
      end
      reg_read(CNT_ADDR, d);
      checks++;
      if (d !== 32'd0) begin
         errors++;
         $display("FAIL post_reset_cnt: got %0d, required 0", d);
      end
      send(4'd0, 5, 6, 7);
      drain();
      checks++;
      if (last_z !== 64'sd5) begin
         errors++;
         $display("FAIL post_reset_pass: got %0d, required 5", last_z);
      end
   endtask

   initial begin
      rst_n = 1'b1; reg_wr = 1'b0; reg_rd = 1'b0; reg_addr = '0; reg_wr_data = '0;
      in_valid = 1'b0; in_ch = '0; a = '0; b = '0; c = '0; out_ready = 1'b1;
      stim_done = 1'b0; last_z = '0; last_ovf = 1'b0; last_err = 1'b0;
      model_reset();
      fork
         monitor_loop();
      join_none
      test_reset();
      test_add_sub();
      test_back_to_back();
      test_acc_stall();
      test_saturation();
      test_bad_inputs();
      test_random();
      test_reset_inflight();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
